// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control sequencer: fetch/decode/execute/memory/write-back.
// Optional JAL support is built when MC_JAL_EN is defined.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state
);

  // Memory handshake: mem_ready high in FETCH, MEMRD or MEMWR completes the
  // access requested that cycle; everywhere else it is ignored.

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MC_JAL_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_WBMEM   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_WBALU   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MC_JAL_EN
    S_JAL     = 4'd9,
`endif
    S_TRAP    = 4'd15
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    instr_retired = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // PC-relative target lands in ALUOut for BEQ/JAL.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADDR;
        else if (opcode == OP_R)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
`ifdef MC_JAL_EN
        else if (opcode == OP_JAL)              state_d = S_JAL;
`endif
        else                                    state_d = S_TRAP;
      end
      S_MEMADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_TRAP;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_WBMEM;
      end
      S_WBMEM: begin
        reg_write     = 1'b1;
        mem_to_reg    = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        mem_write     = 1'b1;
        i_or_d        = 1'b1;
        instr_retired = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_WBALU;
      end
      S_WBALU: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        reg_write     = 1'b1;
        mem_to_reg    = 2'b10;
        pc_write      = 1'b1;
        pc_source     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
`endif
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    // Nothing, including a fetch request, may leave the block during reset.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 1'b0;
      instr_retired = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected outputs queued by the driver,
// checked by an independent monitor on the falling edge.
module tb_mc_control_fsm;
  localparam int W = 22;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, pc_source, instr_retired, illegal;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  int total = 0;
  int bad = 0;
  int cyc = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .instr_retired(instr_retired), .illegal(illegal), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign act = {state, pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_retired, illegal};

  // ctl = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, reg_write}
  function automatic logic [W-1:0] pk(input logic [3:0] st, input logic [6:0] ctl,
                                      input logic [1:0] m2r, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op,
                                      input logic pcs, input logic ret, input logic ill);
    return {st, ctl, m2r, a, b, op, pcs, ret, ill};
  endfunction

  // Hand-written expected vectors per state
  logic [W-1:0] e_rst, e_f1, e_f0, e_dec, e_ma, e_rd, e_wbm, e_wr0, e_wr1;
  logic [W-1:0] e_ex, e_wba, e_br, e_jal, e_trap;
  initial begin
    e_rst  = pk(4'd0,  7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    e_f1   = pk(4'd0,  7'b1011000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    e_f0   = pk(4'd0,  7'b0001000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    e_dec  = pk(4'd1,  7'b0000000, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    e_ma   = pk(4'd2,  7'b0000000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    e_rd   = pk(4'd3,  7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    e_wbm  = pk(4'd4,  7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    e_wr0  = pk(4'd5,  7'b0000110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    e_wr1  = pk(4'd5,  7'b0000110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    e_ex   = pk(4'd6,  7'b0000000, 2'b00, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    e_wba  = pk(4'd7,  7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    e_br   = pk(4'd8,  7'b0100000, 2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0);
    e_jal  = pk(4'd9,  7'b1000001, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    e_trap = pk(4'd15, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input logic mr, input logic [W-1:0] e);
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_step(input logic mr);
    reset = 1'b1;
    mem_ready = mr;
    exp_q.push_back(e_rst);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL outputs cycle=%0d got=%h (state=%0d) exp=%h", cyc, act, state, e);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // reset holds everything low even with mem_ready high
    rst_step(1'b1);
    rst_step(1'b1);
    reset = 1'b0;

    // R-type, zero wait: 0,1,6,7
    opcode = 7'b0110011;
    step(1'b1, e_f1); step(1'b0, e_dec); step(1'b1, e_ex); step(1'b0, e_wba);

    // LW, two wait cycles in MEMRD
    opcode = 7'b0000011;
    step(1'b1, e_f1); step(1'b1, e_dec); step(1'b0, e_ma);
    step(1'b0, e_rd); step(1'b0, e_rd); step(1'b1, e_rd); step(1'b0, e_wbm);

    // SW, three wait cycles in FETCH, one in MEMWR
    opcode = 7'b0100011;
    step(1'b0, e_f0); step(1'b0, e_f0); step(1'b0, e_f0); step(1'b1, e_f1);
    step(1'b0, e_dec); step(1'b1, e_ma); step(1'b0, e_wr0); step(1'b1, e_wr1);

    // BEQ
    opcode = 7'b1100011;
    step(1'b1, e_f1); step(1'b1, e_dec); step(1'b1, e_br);

    // JAL
    opcode = 7'b1101111;
    step(1'b1, e_f1); step(1'b0, e_dec);
`ifdef MC_JAL_EN
    step(1'b0, e_jal);
`else
    step(1'b1, e_trap); step(1'b0, e_trap);
    rst_step(1'b1);
    reset = 1'b0;
`endif

    // reset mid-LW aborts the instruction; then an R-type runs cleanly
    opcode = 7'b0000011;
    step(1'b1, e_f1); step(1'b1, e_dec); step(1'b1, e_ma);
    rst_step(1'b1);
    reset = 1'b0;
    opcode = 7'b0110011;
    step(1'b1, e_f1); step(1'b1, e_dec); step(1'b1, e_ex); step(1'b1, e_wba);

    // illegal opcode: TRAP absorbs for 20 cycles regardless of mem_ready
    opcode = 7'b1111111;
    step(1'b1, e_f1); step(1'b1, e_dec);
    for (int i = 0; i < 20; i++) step(i[0], e_trap);
    rst_step(1'b1);
    reset = 1'b0;
    opcode = 7'b1100011;
    step(1'b1, e_f1); step(1'b1, e_dec); step(1'b1, e_br);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control sequencer for the RV32I core. It decodes the 7-bit opcode from the instruction register and steps the shared datapath (PC, memory port, register file, ALU) through fetch, decode, execute, memory and write-back states. It drives the 2-bit `alu_op` consumed by the existing ALU control decoder and stalls on a memory ready handshake. It replaces the single-cycle main decoder when the core is built as multi-cycle.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  7  instruction register bits [6:0]
- `mem_ready`  in  1  unified memory completes the current access this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero (beq)
- `ir_write`  out  1  load instruction register and OldPC
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `reg_write`  out  1  register-file write enable
- `mem_to_reg`  out  2  write-back select: 00 ALUOut, 01 MDR, 10 PC (link)
- `alu_src_a`  out  2  00 PC, 01 rs1, 10 OldPC
- `alu_src_b`  out  2  00 rs2, 01 constant 4, 10 immediate
- `alu_op`  out  2  00 add, 01 subtract (branch), 10 funct-decoded
- `pc_source`  out  1  0 ALU result, 1 ALUOut
- `instr_retired`  out  1  one-cycle pulse on the final state of each instruction
- `illegal`  out  1  trap indicator, held until reset
- `state`  out  4  current state encoding (debug)

## Operation
- Opcodes: R 0110011, LW 0000011, SW 0100011, BEQ 1100011, JAL 1101111.
- State register is the only storage. Outputs decode the state combinationally. Any output not listed for a state is 0.
- S0 FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_source`=0.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy).
  - Stays in FETCH while `mem_ready`=0; otherwise goes to DECODE.
- S1 DECODE:
  - Drives `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00. This latches the branch/jump target in ALUOut.
  - Next state: LW/SW go to MEMADDR, R goes to EXEC, BEQ goes to BRANCH, JAL goes to JAL (macro-gated), anything else goes to TRAP.
- S2 MEMADDR: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. LW goes to MEMRD; SW goes to MEMWR.
- S3 MEMRD: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to WBMEM.
- S4 WBMEM: `reg_write`=1, `mem_to_reg`=01, `instr_retired`=1. Goes to FETCH.
- S5 MEMWR: `mem_write`=1, `i_or_d`=1. Waits for `mem_ready`; `instr_retired` equals `mem_ready`. Then goes to FETCH.
- S6 EXEC: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=10. Goes to WBALU.
- S7 WBALU: `reg_write`=1, `mem_to_reg`=00, `instr_retired`=1. Goes to FETCH.
- S8 BRANCH: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=1, `instr_retired`=1. Goes to FETCH.
- S9 JAL: `reg_write`=1, `mem_to_reg`=10, `pc_write`=1, `pc_source`=1, `instr_retired`=1. Goes to FETCH.
- S15 TRAP: `illegal`=1, all other outputs 0. Absorbing; only `reset` exits.
- Unused encodings (10–14) go to TRAP on the next edge.
- `opcode` is sampled only in DECODE and MEMADDR. It must be stable from the end of FETCH until the instruction retires.

## Timing
- `reset` asserted: `state`=0 (FETCH) asynchronously. Every output is forced 0 combinationally while `reset`=1. This includes `mem_read`; no memory request is issued during reset.
- First FETCH request is issued in the first cycle after `reset` deasserts.
- Latency with zero-wait memory (counted from the FETCH cycle to the retire cycle, inclusive):
  - R: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - JAL: 3 cycles
- Each memory wait cycle adds 1 cycle. Outputs hold constant throughout a stall.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction aborts it. No `instr_retired` pulse is produced, and no write is issued after the reset edge.
- `instr_retired` is high for exactly one cycle per completed instruction and never in TRAP.

## Configuration
- `MC_JAL_EN` defined:
  - Opcode 1101111 goes DECODE → JAL.
  - `mem_to_reg`=10 is reachable.
- `MC_JAL_EN` undefined:
  - S9 is not built.
  - Opcode 1101111 goes DECODE → TRAP.
  - `mem_to_reg[1]` is constant 0.

## Test plan
- Reset, then release with `mem_ready`=1 and `opcode`=0110011 → states 0,1,6,7,0. `alu_op`=10 in S6. `reg_write`=1 and `instr_retired`=1 in S7.
- LW with `mem_ready` low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. `i_or_d`=1 in S3. `mem_to_reg`=01 in S4. Total 7 cycles.
- SW with `mem_ready` low for 3 cycles in FETCH → `pc_write`=`ir_write`=0 while stalled, then 1 for a single cycle. `mem_write`=1 in S5 with no `reg_write`.
- BEQ → S8 shows `alu_op`=01, `pc_write_cond`=1, `pc_source`=1. Returns to FETCH after 3 cycles.
- `opcode`=1111111 → TRAP. `illegal`=1 and `state`=15 hold for 20 cycles. Asserting `reset` returns `state` to 0 with `illegal`=0 immediately.
- `opcode`=1101111: with `MC_JAL_EN` → S9 with `reg_write`=1, `mem_to_reg`=10, `pc_write`=1. Without `MC_JAL_EN` → TRAP.
